// File: rtl/grid_scan_driver_pkg.sv
// Shared types and constants for the LED grid scan driver.
package grid_pkg;
  typedef logic [63:0] grid_t;
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, DWELL} scan_state_t;

  localparam int GRID_ROWS = 8;
  localparam int GRID_COLS = 8;
  localparam int WORD_BITS = 16;

  // Serial word for one row: active-low row select, then column bits (col 7 first).
  function automatic logic [WORD_BITS-1:0] row_word(input grid_t g, input logic [2:0] r);
    logic [7:0] one;
    one = 8'd1;
    return {~(one << r), g[8*r +: GRID_COLS]};
  endfunction
endpackage

// File: rtl/grid_scan_driver_serial_shifter.sv
// 16-bit MSB-first serializer: sclk low CLK_DIV clocks then high CLK_DIV clocks per bit.
module serial_shifter
  import grid_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [WORD_BITS-1:0] word_i,
  output logic                 sclk_o,
  output logic                 sdata_o,
  output logic                 done_o
);
  localparam int DW = $clog2(2*CLK_DIV) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(2*CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HI   = DW'(CLK_DIV);

  logic [DW-1:0]        div_q;
  logic [3:0]           bit_q;
  logic [WORD_BITS-1:0] sh_q;
  logic                 busy_q, sclk_q, sdata_q;
  logic                 last_phase;

  assign last_phase = (div_q == DIV_LAST);
  // Asserted during the final clock of bit 15 so the caller can leave SHIFT on time.
  assign done_o  = busy_q && last_phase && (bit_q == 4'd15);
  assign sclk_o  = sclk_q;
  assign sdata_o = sdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
    end else if (start_i) begin
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= word_i;
      busy_q  <= 1'b1;
      sclk_q  <= 1'b0;
      sdata_q <= word_i[WORD_BITS-1];
    end else if (busy_q) begin
      if (last_phase) begin
        div_q  <= '0;
        sclk_q <= 1'b0;
        if (bit_q == 4'd15) begin
          busy_q <= 1'b0;
        end else begin
          bit_q   <= bit_q + 4'd1;
          sh_q    <= sh_q << 1;
          sdata_q <= sh_q[WORD_BITS-2];
        end
      end else begin
        div_q  <= div_q + DW'(1);
        sclk_q <= ((div_q + DW'(1)) >= DIV_HI);
      end
    end
  end
endmodule

// File: rtl/grid_scan_driver.sv
// Snapshots a 64-bit Life grid per frame and scans it row by row into two chained SIPO registers.
// Build option: define GRID_SCAN_BLANK_EN to blank the display (oe_n=1) while shifting and latching.
module grid_scan_driver
  import grid_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int DWELL_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [63:0] grid,
  output logic        sclk,
  output logic        sdata,
  output logic        latch,
  output logic        oe_n,
  output logic [2:0]  row_idx,
  output logic        frame_done
);
  localparam logic [31:0] LATCH_LAST = 32'(CLK_DIV - 1);
  localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);
  localparam logic [2:0]  LAST_ROW   = 3'(GRID_ROWS - 1);

  scan_state_t state_q, state_d;
  grid_t       snap_q, snap_d;
  logic [2:0]  row_q, row_d;
  logic [31:0] cnt_q, cnt_d;
  logic        latch_q, latch_d, oe_n_q, oe_n_d, fdone_q, fdone_d;
  logic        start, sh_done;

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    unique case (state_q)
      IDLE:  if (enable) state_d = LOAD;
      LOAD: begin
        snap_d  = grid;
        row_d   = '0;
        start   = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: if (sh_done) begin
        cnt_d   = '0;
        state_d = LATCH;
      end
      LATCH: if (cnt_q == LATCH_LAST) begin
        cnt_d   = '0;
        state_d = DWELL;
      end else cnt_d = cnt_q + 32'd1;
      DWELL: if (cnt_q == DWELL_LAST) begin
        cnt_d = '0;
        if (row_q == LAST_ROW) begin
          state_d = enable ? LOAD : IDLE;
        end else begin
          row_d   = row_q + 3'd1;
          start   = 1'b1;
          state_d = SHIFT;
        end
      end else cnt_d = cnt_q + 32'd1;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from next-state so they line up with the state they describe.
    latch_d = (state_d == LATCH);
    fdone_d = (state_d == DWELL) && (cnt_d == DWELL_LAST) && (row_d == LAST_ROW);
`ifdef GRID_SCAN_BLANK_EN
    oe_n_d  = (state_d != DWELL);
`else
    oe_n_d  = !((state_d == SHIFT) || (state_d == LATCH) || (state_d == DWELL));
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      snap_q  <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      latch_q <= 1'b0;
      oe_n_q  <= 1'b1;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
      oe_n_q  <= oe_n_d;
      fdone_q <= fdone_d;
    end
  end

  serial_shifter #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk     (clk),
    .reset   (reset),
    .start_i (start),
    .word_i  (row_word(snap_d, row_d)),
    .sclk_o  (sclk),
    .sdata_o (sdata),
    .done_o  (sh_done)
  );

  assign latch      = latch_q;
  assign oe_n       = oe_n_q;
  assign row_idx    = row_q;
  assign frame_done = fdone_q;
endmodule

// File: doc/grid_scan_driver.md
Name: grid_scan_driver

Overview:
- Consumer end of the 64-bit grid bus that the Game of Life core produces.
- Snapshots the grid once per frame and drives an 8x8 LED matrix row by row.
- Output goes through two daisy-chained 8-bit serial-in/parallel-out shift registers (row-select first, column data second).
- Sits between the game top level and the board pins.

Parameters:
- CLK_DIV, 4, system clocks per sclk phase (low and high each last CLK_DIV); must be >= 1.
- DWELL_CYCLES, 1000, clocks a row stays lit after its latch pulse; must be >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  run scanning; sampled in IDLE and at frame end.
- grid  input  64  cell states; row r = grid[8r+7:8r], column c = bit 8r+c.
- sclk  output  1  shift-register clock; data is sampled on its rising edge.
- sdata  output  1  serial data, MSB first.
- latch  output  1  storage-register strobe, active-high.
- oe_n  output  1  output enable to the shift registers, active-low.
- row_idx  output  3  row currently being shifted or displayed.
- frame_done  output  1  one-cycle pulse at the end of row 7 dwell.

Behaviour:
- Reset:
  - state IDLE.
  - sclk=0, sdata=0, latch=0, oe_n=1, row_idx=0, frame_done=0.
  - Snapshot register cleared; all counters cleared.
  - Reset takes effect on the next edge from any state, including mid-shift or mid-dwell.
- States: IDLE, LOAD, SHIFT, LATCH, DWELL.
- IDLE:
  - oe_n=1.
  - enable=1 moves to LOAD.
- LOAD (1 cycle):
  - snap <= grid; row_idx <= 0; then SHIFT.
  - grid is ignored at all other times, so there is no tearing.
- SHIFT:
  - Shifts the 16-bit word {row_sel_n[7:0], col[7:0]}, MSB first.
  - row_sel_n = ~(8'b1 << row_idx).
  - col = snap[8*row_idx +: 8], with col[7] = column 7.
  - Each bit: sdata is set at bit start; sclk is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - 16 bits take 32*CLK_DIV cycles; sclk returns to 0 at exit.
- LATCH:
  - latch=1 for CLK_DIV cycles; sclk=0; then DWELL.
- DWELL:
  - DWELL_CYCLES cycles with oe_n=0.
  - If row_idx<7: row_idx+1, then SHIFT.
  - If row_idx==7: frame_done=1 in the final dwell cycle; next state is LOAD if enable=1, else IDLE.
- Timing:
  - Row period = 32*CLK_DIV + CLK_DIV + DWELL_CYCLES.
  - Continuous frame period = 1 + 8*row period.
- oe_n (default build): 0 in SHIFT, LATCH and DWELL; 1 in IDLE and LOAD.
- Deasserting enable mid-frame does not truncate: the current frame completes, then the block goes to IDLE.
- sdata holds its last value outside SHIFT; it is 0 after reset.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro GRID_SCAN_BLANK_EN.
- Defined: oe_n=1 during SHIFT and LATCH, so the display is blanked while new row data moves; this eliminates ghosting. oe_n=0 only in DWELL.
- Undefined: oe_n follows the default rule (0 throughout SHIFT, LATCH and DWELL).

Decomposition:
- Package grid_pkg:
  - typedef grid_t (logic [63:0]).
  - typedef scan_state_t enum {IDLE, LOAD, SHIFT, LATCH, DWELL}.
  - Constants GRID_ROWS=8, GRID_COLS=8, WORD_BITS=16.
- One sub-module, serial_shifter: 16-bit parallel load, sclk generation with CLK_DIV, done pulse.
- The FSM, snapshot register, row counter and dwell counter stay in the top module.

Test Plan:
- Reset check: CLK_DIV=2, DWELL_CYCLES=8, reset mid-SHIFT -> next cycle sclk=0, latch=0, oe_n=1, row_idx=0, state IDLE.
- Row 0 word: grid=64'h0000_0000_0000_00A5, enable=1 -> 16 sclk rising edges; captured word 16'hFEA5; latch high 2 cycles; oe_n=0 for 8 dwell cycles.
- Diagonal frame: grid=64'h8040_2010_0804_0201 -> per-row captured words {~(1<<r), 1<<r} for r=0..7; frame_done pulses once, 593 cycles after LOAD.
- Snapshot hold: change grid to all ones during row 3 -> rows 4-7 still show the old snapshot; the next frame shows col=8'hFF on every row.
- Enable drop: deassert enable during row 2 -> rows 3-7 complete, frame_done pulses, then IDLE with oe_n=1 and no further sclk edges.
- Blanking build: with GRID_SCAN_BLANK_EN defined -> oe_n=1 throughout SHIFT and LATCH and 0 only during DWELL; without it -> oe_n=0 from SHIFT entry through DWELL.
